// File: rtl/i2c_slave_sync.sv
// rtl/i2c_slave_sync.sv - oversampled I2C slave with glitch filter and byte strobes
// SCL/SDA are synchronised and filtered; all protocol decisions use the filtered edges.
module i2c_slave_sync #(
  parameter logic [6:0] ADDR       = 7'h2A,
  parameter int         FILTER_LEN = 3,
  parameter int         MAX_BYTES  = 16,
  localparam int        BW         = $clog2(MAX_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic [7:0]    tx_data,
  output logic          tx_req,
  output logic          busy,
  output logic [3:0]    state_out,
  output logic [BW-1:0] byte_cnt
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [3:0] {
    IDLE = 4'd0, ADDR_S = 4'd1, ADDR_ACK = 4'd2, WR_BYTE = 4'd3,
    WR_ACK = 4'd4, RD_BYTE = 4'd5, RD_ACK = 4'd6, WAIT_STOP = 4'd7
  } state_t;

  // index 1 = SCL, index 0 = SDA
  logic [1:0]    sync1, sync2, filt, filt_d;
  logic [FW-1:0] fcnt [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      filt_d  <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1  <= {scl_i, sda_i};
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;
  assign scl_f    = filt[1];
  assign sda_f    = filt[0];
  assign scl_rise = scl_f & ~filt_d[1];
  assign scl_fall = ~scl_f & filt_d[1];
  assign start_c  = scl_f & filt_d[0] & ~sda_f;
  assign stop_c   = scl_f & ~filt_d[0] & sda_f;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       rw;
  logic [7:0] shifted;
  assign shifted   = {shreg[6:0], sda_f};
  assign state_out = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
      byte_cnt <= '0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (start_c) begin
        state    <= ADDR_S;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        sda_oe   <= 1'b0;
      end else if (stop_c) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ADDR_S: if (scl_rise) begin
            shreg   <= shifted;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (shifted[7:1] == ADDR) begin
                busy  <= 1'b1;
                rw    <= shifted[0];
                state <= ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end
            end
          end
          // sda_oe doubles as the phase flag: low = ACK not yet driven
          ADDR_ACK: begin
            if (scl_rise && rw && sda_oe) begin
              tx_req <= 1'b1;
            end else if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else if (rw) begin
                shreg   <= {tx_data[6:0], 1'b0};
                sda_oe  <= ~tx_data[7];
                bit_cnt <= 4'd1;
                state   <= RD_BYTE;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= WR_BYTE;
              end
            end
          end
          WR_BYTE: if (scl_rise) begin
            shreg   <= shifted;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (byte_cnt < BW'(MAX_BYTES)) begin
                rx_data  <= shifted;
                rx_valid <= 1'b1;
                byte_cnt <= byte_cnt + BW'(1);
                state    <= WR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              state  <= WR_BYTE;
            end
          end
          RD_BYTE: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe <= 1'b0;
              state  <= RD_ACK;
              if (byte_cnt != '1) byte_cnt <= byte_cnt + BW'(1);
            end else begin
              sda_oe  <= ~shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          // a fall here always follows an ACK=0 rise, since NACK leaves the state
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_f) begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end else begin
                tx_req <= 1'b1;
              end
            end else if (scl_fall) begin
              shreg   <= {tx_data[6:0], 1'b0};
              sda_oe  <= ~tx_data[7];
              bit_cnt <= 4'd1;
              state   <= RD_BYTE;
            end
          end
          WAIT_STOP: begin
            sda_oe <= 1'b0;
            busy   <= 1'b0;
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_sync.sv
// tb/tb_i2c_slave_sync.sv - bus-level master, byte-level model and per-cycle compare
module tb_i2c_slave_sync;
  localparam int MAXB = 2;
  localparam int BW   = $clog2(MAXB + 1);
  localparam int Q    = 10;

  logic          clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
  logic          sda_oe, rx_valid, tx_req, busy;
  logic [7:0]    rx_data, tx_data = 8'h00;
  logic [3:0]    state_out;
  logic [BW-1:0] byte_cnt;
  wire           sda_line = sda_m & ~sda_oe;

  int vectors = 0, miscompares = 0, tx_req_cnt = 0;
  bit allow_drive = 1'b0, prev_owned = 1'b0;
  logic [7:0] rx_exp[$], tx_sent[$], tx_plan[$], wr_plan[$];
  logic [7:0] last_rd;

  always #5 clk = ~clk;

  i2c_slave_sync #(.ADDR(7'h2A), .FILTER_LEN(3), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
    .busy(busy), .state_out(state_out), .byte_cnt(byte_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (!allow_drive) check("sda_oe_unexpected", sda_oe, 0);
      if (rx_valid) begin
        if (rx_exp.size() == 0) check("rx_valid_unexpected", rx_valid, 0);
        else check("rx_data", rx_data, rx_exp.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && tx_req) begin
      tx_data = (tx_plan.size() != 0) ? tx_plan.pop_front() : 8'($urandom);
      tx_sent.push_back(tx_data);
      tx_req_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_bit(input bit owned, input bit val, input bit glitch, output bit line);
    allow_drive = prev_owned | owned;
    tick(Q);
    allow_drive = owned;
    prev_owned  = owned;
    sda_m = owned ? 1'b1 : val;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    line = sda_line;
    if (glitch) begin
      sda_m = ~sda_m; tick(2); sda_m = ~sda_m; tick(Q - 2);
    end else begin
      tick(Q);
    end
    scl_m = 1'b0;
  endtask

  task automatic do_start(input bit repeated);
    if (repeated) begin
      allow_drive = prev_owned; tick(Q);
      allow_drive = 1'b0; prev_owned = 1'b0;
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
    end
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0;
  endtask

  task automatic do_stop();
    allow_drive = prev_owned; tick(Q);
    allow_drive = 1'b0; prev_owned = 1'b0;
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
    check("stop_state", state_out, 0);
    check("stop_busy", busy, 0);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit glitch, output bit ack);
    bit l;
    for (int i = 7; i >= 0; i--) do_bit(1'b0, b[i], glitch && (i == 3), l);
    do_bit(1'b1, 1'b1, 1'b0, l);
    ack = ~l;
  endtask

  task automatic read_byte(input bit master_ack, output logic [7:0] b);
    bit l;
    for (int i = 7; i >= 0; i--) begin
      do_bit(1'b1, 1'b1, 1'b0, l);
      b[i] = l;
    end
    do_bit(1'b0, ~master_ack, 1'b0, l);
  endtask

  task automatic xfer(input logic [6:0] a, input bit rd, input int n, input bit glitch);
    bit ack, match;
    logic [7:0] b;
    int cnt, sat;
    match = (a == 7'h2A);
    cnt = 0;
    tx_req_cnt = 0;
    write_byte({a, rd}, 1'b0, ack);
    check("addr_ack", ack, match);
    if (!match) begin
      check("mismatch_state", state_out, 7);
      check("mismatch_busy", busy, 0);
      return;
    end
    check("match_busy", busy, 1);
    if (!rd) begin
      for (int i = 0; i < n; i++) begin
        b = (wr_plan.size() != 0) ? wr_plan.pop_front() : 8'($urandom);
        if (cnt < MAXB) rx_exp.push_back(b);
        write_byte(b, glitch && (i == 0), ack);
        check("data_ack", ack, cnt < MAXB);
        if (cnt >= MAXB) begin
          check("nack_state", state_out, 7);
          check("nack_busy", busy, 0);
          break;
        end
        cnt++;
      end
      check("wr_byte_cnt", byte_cnt, cnt);
      check("wr_rx_drained", rx_exp.size(), 0);
      check("wr_tx_req_cnt", tx_req_cnt, 0);
    end else begin
      for (int i = 0; i < n; i++) begin
        read_byte(i < n - 1, b);
        last_rd = b;
        check("rd_tx_req_seen", tx_sent.size() > 0, 1);
        if (tx_sent.size() > 0) check("rd_byte", b, tx_sent.pop_front());
      end
      sat = (n < (1 << BW) - 1) ? n : (1 << BW) - 1;
      check("rd_tx_req_cnt", tx_req_cnt, n);
      check("rd_byte_cnt", byte_cnt, sat);
      check("rd_nack_state", state_out, 7);
    end
  endtask

  initial begin
    bit ack, l;
    tick(5);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_out, 0);
    check("rst_byte_cnt", byte_cnt, 0);
    rst = 1'b0;
    tick(10);

    // 1: two-byte write
    wr_plan = '{8'hA5, 8'h3C};
    do_start(1'b0); xfer(7'h2A, 1'b0, 2, 1'b0); do_stop();
    check("t1_rx_data", rx_data, 8'h3C);
    check("t1_byte_cnt", byte_cnt, 2);

    // 2: wrong address
    do_start(1'b0); xfer(7'h2B, 1'b0, 1, 1'b0); do_stop();

    // 3: two-byte read with scripted answers
    tx_plan = '{8'h81, 8'h7E};
    do_start(1'b0); xfer(7'h2A, 1'b1, 2, 1'b0);
    check("t3_last_rd", last_rd, 8'h7E);
    do_stop();

    // 4: write then repeated START into a read
    wr_plan = '{8'h10};
    do_start(1'b0); xfer(7'h2A, 1'b0, 1, 1'b0);
    do_start(1'b1);
    check("t4_sr_state", state_out, 1);
    check("t4_sr_byte_cnt", byte_cnt, 0);
    check("t4_rx_data", rx_data, 8'h10);
    xfer(7'h2A, 1'b1, 2, 1'b0); do_stop();

    // 5: one byte beyond the limit
    wr_plan = '{8'h11, 8'h22, 8'h33};
    do_start(1'b0); xfer(7'h2A, 1'b0, 3, 1'b0); do_stop();
    check("t5_byte_cnt", byte_cnt, 2);

    // 6: glitches in idle and while SCL is high mid-byte
    sda_m = 1'b0; tick(2); sda_m = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("idle_glitch_state", state_out, 0);
    end
    wr_plan = '{8'hF0};
    do_start(1'b0); xfer(7'h2A, 1'b0, 1, 1'b1); do_stop();
    wr_plan = '{8'h0F};
    do_start(1'b0); xfer(7'h2A, 1'b0, 1, 1'b1); do_stop();

    // reset while the slave is pulling SDA low during a read
    tx_plan = '{8'h00};
    do_start(1'b0); write_byte({7'h2A, 1'b1}, 1'b0, ack);
    check("rst_case_ack", ack, 1);
    for (int i = 0; i < 3; i++) do_bit(1'b1, 1'b1, 1'b0, l);
    allow_drive = 1'b1;
    tick(Q);
    check("pre_rst_sda_oe", sda_oe, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_sda_oe", sda_oe, 0);
    check("mid_rst_state", state_out, 0);
    tick(2);
    allow_drive = 1'b0; prev_owned = 1'b0;
    scl_m = 1'b1; sda_m = 1'b1;
    tick(20);
    rst = 1'b0;
    tx_sent.delete();
    tick(20);
    check("post_rst_state", state_out, 0);

    // randomized transactions
    for (int t = 0; t < 16; t++) begin
      logic [6:0] a;
      a = ($urandom_range(0, 9) < 6) ? 7'h2A : 7'($urandom);
      do_start(1'b0);
      xfer(a, 1'($urandom), int'($urandom_range(1, 4)), ($urandom_range(0, 3) == 0));
      do_stop();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
